// File: rtl/spectral_peak_tracker.sv
// rtl/spectral_peak_tracker.sv - per-frame peak bin search with neighbour magnitudes
//
// Consumes one FFT frame of complex bins in index order and squares each bin
// through a 2-stage pipeline. Tracks the strongest bin in [bin_lo, bin_hi]
// with its in-window left/right neighbours. Reports once per frame with a
// one-cycle result_valid, 3 cycles after fft_last is accepted.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   fft_valid/index/re/im/last input bin stream
//   bin_lo, bin_hi, threshold  search window and peak threshold, latched at frame start
//   busy                       frame in progress or draining
//   result_valid               one-cycle strobe, result fields updated
//   peak_found/index/mag       strongest in-window bin and threshold flag
//   left_mag, right_mag        in-window neighbour magnitudes (0 at window edge)
//   overrun                    sample dropped while draining/reporting
module spectral_peak_tracker #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 9,
    localparam int MAG_W = 2 * DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fft_valid,
    input  logic [ADDR_W-1:0]        fft_index,
    input  logic signed [DATA_W-1:0] fft_re,
    input  logic signed [DATA_W-1:0] fft_im,
    input  logic                     fft_last,
    input  logic [ADDR_W-1:0]        bin_lo,
    input  logic [ADDR_W-1:0]        bin_hi,
    input  logic [MAG_W-1:0]         threshold,
    output logic                     busy,
    output logic                     result_valid,
    output logic                     peak_found,
    output logic [ADDR_W-1:0]        peak_index,
    output logic [MAG_W-1:0]         peak_mag,
    output logic [MAG_W-1:0]         left_mag,
    output logic [MAG_W-1:0]         right_mag,
    output logic                     overrun
);

    typedef enum logic [1:0] {IDLE, FRAME, FLUSH, REPORT} state_t;

    state_t              state;
    logic                flush_cnt;
    logic [ADDR_W-1:0]   lo_q, hi_q;
    logic [MAG_W-1:0]    thr_q;

    // Pipeline registers
    logic                     s1_valid, s1_win;
    logic signed [MAG_W-1:0]  s1_re2, s1_im2;
    logic [ADDR_W-1:0]        s1_idx;
    logic                     s2_valid, s2_win;
    logic [MAG_W-1:0]         s2_mag;
    logic [ADDR_W-1:0]        s2_idx;

    // Tracker state and its next values
    logic [MAG_W-1:0]   cur_max, cur_left, cur_right, prev_mag;
    logic [ADDR_W-1:0]  cur_idx;
    logic               want_right, seen;
    logic [MAG_W-1:0]   nxt_max, nxt_left, nxt_right, nxt_prev;
    logic [ADDR_W-1:0]  nxt_idx;
    logic               nxt_want, nxt_seen;

    logic                    accept;
    logic                    in_win;
    logic [ADDR_W-1:0]       lo_eff, hi_eff;
    logic signed [MAG_W-1:0] re_x, im_x;

    assign accept = fft_valid && (state == IDLE || state == FRAME);
    // The first sample of a frame is judged against the live window inputs,
    // since they are only being latched on that same cycle.
    assign lo_eff = (state == IDLE) ? bin_lo : lo_q;
    assign hi_eff = (state == IDLE) ? bin_hi : hi_q;
    assign in_win = (fft_index >= lo_eff) && (fft_index <= hi_eff);
    assign re_x   = MAG_W'(fft_re);
    assign im_x   = MAG_W'(fft_im);

    assign busy    = (state != IDLE);
    assign overrun = !reset && fft_valid && (state == FLUSH || state == REPORT);

    always_comb begin
        nxt_max   = cur_max;
        nxt_idx   = cur_idx;
        nxt_left  = cur_left;
        nxt_right = cur_right;
        nxt_want  = want_right;
        nxt_seen  = seen;
        nxt_prev  = prev_mag;
        if (s2_valid && s2_win) begin
            // Strict compare keeps the lowest index on ties.
            if (!seen || s2_mag > cur_max) begin
                nxt_max   = s2_mag;
                nxt_idx   = s2_idx;
                nxt_left  = prev_mag;
                nxt_right = '0;
                nxt_want  = 1'b1;
            end else if (want_right) begin
                nxt_right = s2_mag;
                nxt_want  = 1'b0;
            end
            nxt_prev = s2_mag;
            nxt_seen = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            flush_cnt    <= 1'b0;
            lo_q         <= '0;
            hi_q         <= '0;
            thr_q        <= '0;
            s1_valid     <= 1'b0;
            s1_win       <= 1'b0;
            s1_re2       <= '0;
            s1_im2       <= '0;
            s1_idx       <= '0;
            s2_valid     <= 1'b0;
            s2_win       <= 1'b0;
            s2_mag       <= '0;
            s2_idx       <= '0;
            cur_max      <= '0;
            cur_idx      <= '0;
            cur_left     <= '0;
            cur_right    <= '0;
            prev_mag     <= '0;
            want_right   <= 1'b0;
            seen         <= 1'b0;
            result_valid <= 1'b0;
            peak_found   <= 1'b0;
            peak_index   <= '0;
            peak_mag     <= '0;
            left_mag     <= '0;
            right_mag    <= '0;
        end else begin
            s1_valid <= accept;
            s1_win   <= in_win;
            s1_re2   <= re_x * re_x;
            s1_im2   <= im_x * im_x;
            s1_idx   <= fft_index;

            // Squares are non-negative, so the unsigned sum fits MAG_W even
            // for two full-scale negative components.
            s2_valid <= s1_valid;
            s2_win   <= s1_win;
            s2_mag   <= $unsigned(s1_re2) + $unsigned(s1_im2);
            s2_idx   <= s1_idx;

            cur_max    <= nxt_max;
            cur_idx    <= nxt_idx;
            cur_left   <= nxt_left;
            cur_right  <= nxt_right;
            prev_mag   <= nxt_prev;
            want_right <= nxt_want;
            seen       <= nxt_seen;

            result_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (fft_valid) begin
                        lo_q      <= bin_lo;
                        hi_q      <= bin_hi;
                        thr_q     <= threshold;
                        flush_cnt <= 1'b0;
                        state     <= fft_last ? FLUSH : FRAME;
                    end
                end
                FRAME: begin
                    if (fft_valid && fft_last) begin
                        flush_cnt <= 1'b0;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        // Last sample leaves stage 2 this cycle: load results
                        // from the tracker's next values.
                        state        <= REPORT;
                        result_valid <= 1'b1;
                        peak_found   <= nxt_max > thr_q;
                        peak_index   <= nxt_idx;
                        peak_mag     <= nxt_max;
                        left_mag     <= nxt_left;
                        right_mag    <= nxt_right;
                    end
                end
                REPORT: begin
                    state      <= IDLE;
                    cur_max    <= '0;
                    cur_idx    <= '0;
                    cur_left   <= '0;
                    cur_right  <= '0;
                    prev_mag   <= '0;
                    want_right <= 1'b0;
                    seen       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spectral_peak_tracker.sv
// tb/tb_spectral_peak_tracker.sv - self-checking bench for spectral_peak_tracker
module tb_spectral_peak_tracker;

    localparam int DATA_W = 18;
    localparam int ADDR_W = 9;
    localparam int MAG_W  = 36;

    logic                     clk;
    logic                     reset;
    logic                     fft_valid;
    logic [ADDR_W-1:0]        fft_index;
    logic signed [DATA_W-1:0] fft_re;
    logic signed [DATA_W-1:0] fft_im;
    logic                     fft_last;
    logic [ADDR_W-1:0]        bin_lo;
    logic [ADDR_W-1:0]        bin_hi;
    logic [MAG_W-1:0]         threshold;
    logic                     busy;
    logic                     result_valid;
    logic                     peak_found;
    logic [ADDR_W-1:0]        peak_index;
    logic [MAG_W-1:0]         peak_mag;
    logic [MAG_W-1:0]         left_mag;
    logic [MAG_W-1:0]         right_mag;
    logic                     overrun;

    spectral_peak_tracker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .fft_valid(fft_valid), .fft_index(fft_index), .fft_re(fft_re),
        .fft_im(fft_im), .fft_last(fft_last),
        .bin_lo(bin_lo), .bin_hi(bin_hi), .threshold(threshold),
        .busy(busy), .result_valid(result_valid), .peak_found(peak_found),
        .peak_index(peak_index), .peak_mag(peak_mag), .left_mag(left_mag),
        .right_mag(right_mag), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [DATA_W-1:0] re_a [512];
    logic signed [DATA_W-1:0] im_a [512];

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_bins();
        for (int i = 0; i < 512; i++) begin
            re_a[i] = '0;
            im_a[i] = '0;
        end
    endtask

    function automatic longint magf(input int i);
        longint r, m;
        r = re_a[i];
        m = im_a[i];
        return r * r + m * m;
    endfunction

    // Reference: scan the in-window bins as a list, take the first maximum,
    // and its list neighbours.
    task automatic model(input int n, input int lo, input int hi, input longint thr,
                         output longint e_idx, output longint e_mag, output longint e_left,
                         output longint e_right, output longint e_found);
        int q[$];
        int best;
        for (int i = 0; i < n; i++)
            if (i >= lo && i <= hi) q.push_back(i);
        e_idx = 0; e_mag = 0; e_left = 0; e_right = 0; e_found = 0;
        if (q.size() > 0) begin
            best = 0;
            for (int p = 1; p < q.size(); p++)
                if (magf(q[p]) > magf(q[best])) best = p;
            e_idx   = q[best];
            e_mag   = magf(q[best]);
            e_left  = (best > 0) ? magf(q[best-1]) : 0;
            e_right = (best < q.size() - 1) ? magf(q[best+1]) : 0;
            e_found = (e_mag > thr) ? 1 : 0;
        end
    endtask

    task automatic run_frame(input string name, input int n, input int lo, input int hi,
                             input longint thr, input bit inj_ov, input int rst_at,
                             input bit gaps);
        longint e_idx, e_mag, e_left, e_right, e_found;
        int lat, strobes, ovs;
        bit was_reset;
        model(n, lo, hi, thr, e_idx, e_mag, e_left, e_right, e_found);
        was_reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    fft_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            if (i == rst_at) begin
                reset = 1'b1;
                fft_valid = 1'b1;
                fft_index = ADDR_W'(i);
                fft_last = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                was_reset = 1'b1;
                break;
            end
            if (i == 0) begin
                bin_lo = ADDR_W'(lo);
                bin_hi = ADDR_W'(hi);
                threshold = MAG_W'(thr);
            end else begin
                // Window inputs must be ignored once the frame has started.
                bin_lo = ADDR_W'($urandom);
                bin_hi = ADDR_W'($urandom);
                threshold = MAG_W'($urandom);
            end
            fft_valid = 1'b1;
            fft_index = ADDR_W'(i);
            fft_re = re_a[i];
            fft_im = im_a[i];
            fft_last = (i == n - 1);
            @(posedge clk); #1;
        end
        fft_valid = 1'b0;
        fft_last = 1'b0;
        lat = 0; strobes = 0; ovs = 0;
        for (int c = 1; c <= 10; c++) begin
            if (inj_ov && !was_reset && (c == 1 || c == 2)) begin
                fft_valid = 1'b1;
                fft_last = 1'b1;
                fft_index = ADDR_W'(lo);
                fft_re = 18'sd100000;
                fft_im = 18'sd100000;
            end else begin
                fft_valid = 1'b0;
                fft_last = 1'b0;
            end
            @(negedge clk);
            if (result_valid) begin
                strobes++;
                if (lat == 0) lat = c;
            end
            if (overrun) ovs++;
            @(posedge clk); #1;
        end
        fft_valid = 1'b0;
        fft_last = 1'b0;
        @(negedge clk);
        check_val({name, ".busy_idle"}, busy, 0);
        check_val({name, ".overruns"}, ovs, inj_ov && !was_reset ? 2 : 0);
        if (was_reset) begin
            check_val({name, ".strobes"}, strobes, 0);
            check_val({name, ".peak_mag"}, peak_mag, 0);
            check_val({name, ".peak_index"}, peak_index, 0);
        end else begin
            check_val({name, ".latency"}, lat, 3);
            check_val({name, ".strobes"}, strobes, 1);
            check_val({name, ".peak_index"}, peak_index, e_idx);
            check_val({name, ".peak_mag"}, peak_mag, e_mag);
            check_val({name, ".left_mag"}, left_mag, e_left);
            check_val({name, ".right_mag"}, right_mag, e_right);
            check_val({name, ".peak_found"}, peak_found, e_found);
        end
    endtask

    task automatic fill_random(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            if (mode == 0) begin
                re_a[i] = 18'($urandom_range(0, 4000) - 2000);
                im_a[i] = 18'($urandom_range(0, 4000) - 2000);
            end else if (mode == 1) begin
                re_a[i] = 18'($urandom_range(0, 1) ? 3 : -4);
                im_a[i] = 18'($urandom_range(0, 1) ? 4 : -3);
                if ($urandom_range(0, 2) == 0) re_a[i] = '0;
            end else begin
                re_a[i] = 18'($urandom);
                im_a[i] = 18'($urandom);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        fft_valid = 1'b0;
        fft_index = '0;
        fft_re = '0;
        fft_im = '0;
        fft_last = 1'b0;
        bin_lo = '0;
        bin_hi = '0;
        threshold = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst.busy", busy, 0);
        check_val("rst.result_valid", result_valid, 0);
        check_val("rst.peak_found", peak_found, 0);
        check_val("rst.peak_index", peak_index, 0);
        check_val("rst.peak_mag", peak_mag, 0);
        check_val("rst.left_mag", left_mag, 0);
        check_val("rst.right_mag", right_mag, 0);
        check_val("rst.overrun", overrun, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        clear_bins();
        re_a[37] = 18'sd1000;
        re_a[36] = 18'sd600;
        im_a[38] = -18'sd400;
        run_frame("basic", 512, 0, 511, 0, 1'b0, -1, 1'b1);
        check_val("basic.const_mag", peak_mag, 1000000);
        check_val("basic.const_left", left_mag, 360000);
        check_val("basic.const_right", right_mag, 160000);

        clear_bins();
        re_a[10] = 18'sd300; im_a[10] = 18'sd400;
        re_a[20] = 18'sd300; im_a[20] = 18'sd400;
        run_frame("tie", 32, 0, 511, 0, 1'b0, -1, 1'b0);
        check_val("tie.const_idx", peak_index, 10);
        run_frame("tie_thr", 32, 0, 511, 250000, 1'b0, -1, 1'b0);
        check_val("tie_thr.const_found", peak_found, 0);

        clear_bins();
        re_a[50] = 18'sd3000; re_a[100] = 18'sd100; re_a[101] = 18'sd5;
        run_frame("win_lo", 256, 100, 200, 0, 1'b0, -1, 1'b1);
        clear_bins();
        re_a[50] = 18'sd3000; re_a[199] = 18'sd5; re_a[200] = 18'sd100; re_a[201] = 18'sd3000;
        run_frame("win_hi", 256, 100, 200, 0, 1'b0, -1, 1'b1);

        clear_bins();
        re_a[5] = -18'sd131072;
        im_a[5] = -18'sd131072;
        run_frame("fullscale", 16, 0, 511, 0, 1'b0, -1, 1'b0);
        check_val("fullscale.const_mag", peak_mag, 64'd34359738368);

        fill_random(40, 0);
        run_frame("overrun", 40, 0, 511, 0, 1'b1, -1, 1'b0);
        fill_random(400, 0);
        run_frame("empty_win", 400, 300, 200, 0, 1'b0, -1, 1'b0);

        fill_random(512, 0);
        run_frame("midreset", 512, 0, 511, 0, 1'b0, 250, 1'b0);
        clear_bins();
        re_a[3] = 18'sd7; re_a[4] = 18'sd9; re_a[5] = 18'sd2;
        run_frame("after_reset", 8, 0, 511, 10, 1'b0, -1, 1'b0);

        clear_bins();
        re_a[0] = 18'sd50;
        run_frame("single", 1, 0, 0, 0, 1'b0, -1, 1'b0);

        for (int k = 0; k < 10; k++) begin
            int n, lo, hi, mode;
            longint thr;
            n = $urandom_range(1, 64);
            lo = $urandom_range(0, 70);
            hi = $urandom_range(0, 70);
            mode = $urandom_range(0, 2);
            fill_random(n, mode);
            thr = (mode == 1) ? 25 : longint'($urandom_range(0, 3000000));
            run_frame($sformatf("rand%0d", k), n, lo, hi, thr, k[0], -1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spectral_peak_tracker.md
Name: spectral_peak_tracker

Overview:
Streaming, parametrised successor to the FFT-frame peak-search path. Consumes one FFT frame of complex bins in index order and computes each bin's squared magnitude in a 2-stage pipeline. Tracks the strongest bin inside a programmable bin window, together with its left and right neighbour magnitudes for later interpolation. Reports once per frame through a one-cycle result strobe. Sits between the FFT output and the frequency estimator / note lookup.

Parameters:
DATA_W, 18, signed width of fft_re / fft_im
ADDR_W, 9, bin index width; frame length up to 2**ADDR_W bins
MAG_W (localparam), 2*DATA_W, unsigned squared-magnitude width; re^2+im^2 cannot overflow, including full-scale negative inputs

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
fft_valid  in  1  bin sample present this cycle
fft_index  in  ADDR_W  bin index of sample
fft_re  in  DATA_W  signed real part
fft_im  in  DATA_W  signed imaginary part
fft_last  in  1  qualifies final sample of frame (valid only with fft_valid)
bin_lo  in  ADDR_W  lowest bin searched (inclusive)
bin_hi  in  ADDR_W  highest bin searched (inclusive)
threshold  in  MAG_W  minimum peak_mag for peak_found
busy  out  1  frame in progress or draining
result_valid  out  1  one-cycle strobe, result fields updated
peak_found  out  1  peak_mag > threshold
peak_index  out  ADDR_W  index of strongest in-window bin
peak_mag  out  MAG_W  its squared magnitude
left_mag  out  MAG_W  squared magnitude of bin peak_index-1 (0 if peak_index==bin_lo)
right_mag  out  MAG_W  squared magnitude of bin peak_index+1 (0 if peak_index==bin_hi)
overrun  out  1  one-cycle pulse: sample dropped

Behaviour:
- Reset: state IDLE. All outputs 0, including busy, result_valid, overrun and every result field. Internal max, prev_mag, want_right and pipeline valids are cleared.
- Reset mid-frame: partial frame discarded, no result_valid. Reset wins over every simultaneous event.
- States: IDLE, FRAME, FLUSH, REPORT.
- IDLE -> FRAME on the first fft_valid. bin_lo, bin_hi and threshold are latched on that cycle and held for the whole frame.
- If that first sample also has fft_last: go directly to FLUSH.
- FRAME -> FLUSH on fft_valid && fft_last.
- FLUSH: exactly 2 cycles, draining the magnitude pipeline. Then -> REPORT.
- REPORT: 1 cycle. result_valid=1 and result registers loaded, then -> IDLE.
- Latency: result_valid is high exactly 3 cycles after the cycle fft_last is accepted.
- busy=1 in FRAME, FLUSH and REPORT.
- fft_valid during FLUSH or REPORT: sample dropped and overrun=1 that cycle. The current frame result is unaffected. The next frame starts only from IDLE.
- Pipeline stage 1 registers re*re and im*im as signed products. Stage 2 registers their unsigned MAG_W sum, index and in-window flag.
- In-window means bin_lo <= index <= bin_hi. Samples outside the window are ignored by the tracker.
- Tracker acts on stage-2 output for in-window samples:
  - If mag > cur_max, or this is the first in-window sample: cur_max=mag, cur_idx=index, cur_left = prev_in_window_mag (0 for the first in-window sample), cur_right=0, want_right=1.
  - Else if want_right: cur_right=mag, want_right=0.
  - prev_in_window_mag=mag on every in-window sample.
- Ties: strict > comparison, so the lowest index wins.
- Indices are assumed strictly increasing within a frame. Neighbour values are taken from adjacent in-window samples.
- No in-window sample in the frame (including bin_lo > bin_hi): peak_index=0, peak_mag=left_mag=right_mag=0, peak_found=0, result_valid still strobes.
- Result fields hold their value until the next REPORT.

Test Plan:
- 512-bin frame, zeros except bin37=(1000,0), bin36=(600,0), bin38=(0,-400); window 0..511; threshold 0 -> result_valid 3 cycles after last; peak_index=37, peak_mag=1000000, left_mag=360000, right_mag=160000, peak_found=1.
- Equal magnitude (300,400) at bins 10 and 20 -> peak_index=10, peak_mag=250000. Repeat with threshold=250000 -> peak_found=0.
- Window 100..200, largest bin 50, in-window max at 100 with bin101=(5,0) -> peak_index=100, left_mag=0, right_mag=25. Max at 200 -> right_mag=0.
- bin 5 = (-131072,-131072), all others zero -> peak_mag=34359738368 (2^35), no overflow.
- fft_valid on both FLUSH cycles -> overrun pulses twice, result unchanged, state returns to IDLE. bin_lo=300, bin_hi=200 -> peak_found=0, all result fields 0.
- Reset asserted at bin 250 of a frame -> no result_valid. A following clean frame reports correctly, with prior state not leaking into it.
